// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns single-beat commands into one AXI write or read at a time
// and returns BRESP/RRESP (or a synthetic SLVERR on timeout) on a response stream.
module axil_cmd_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  // state   | meaning
  // IDLE    | waiting for a command, cmd_ready high
  // WR_AW_W | AW and W valids out, each dropped after its own handshake
  // WR_B    | bready high, waiting for B or timeout
  // RD_AR   | arvalid out, waiting for arready
  // RD_R    | rready high, waiting for R or timeout
  // RSP     | response presented until rsp_ready
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_e;

  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The compare runs on the last permitted wait cycle, so expiry lands after exactly
  // TIMEOUT_CYCLES cycles spent in WR_B/RD_R.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e                state_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  rsp_valid_q, rsp_timeout_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [1:0]            resp_q;
  logic [TCNT_W-1:0]     tcnt_q;

  logic aw_done, w_done, expired;

  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q || m_axi_wready;
  assign expired = TO_EN && (tcnt_q == TCNT_LAST);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      resp_q        <= '0;
      tcnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            tcnt_q   <= '0;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            resp_q      <= m_axi_bresp;
            rdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (expired) begin
            resp_q        <= 2'b10;
            rdata_q       <= '0;
            rsp_timeout_q <= 1'b1;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        RD_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            tcnt_q    <= '0;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi_rvalid) begin
            resp_q      <= m_axi_rresp;
            rdata_q     <= m_axi_rdata;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (expired) begin
            resp_q        <= 2'b10;
            rdata_q       <= '0;
            rsp_timeout_q <= 1'b1;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE) && s_axi_aresetn;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed and random commands against a delay-programmable
// AXI4-Lite slave, with expected response/latency computed from the transaction rules.
module tb_axil_cmd_master;
  localparam int TO = 16;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_timeout, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic [31:0] m_axi_rdata;

  int total = 0;
  int bad = 0;

  // slave configuration (written by the stimulus) and observations (written by the slave)
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_resp = '0;
  logic [31:0] cfg_rdata = '0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, aw_hi = 0, w_hi = 0;
  logic [8:0]  seen_awaddr = '0, seen_araddr = '0;
  logic [31:0] seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;

  axil_cmd_master #(.ADDR_W(9), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: decides at each falling edge what it presents at the next rising edge.
  // B/R are evaluated before AW/W/AR so a response never starts in the address cycle.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_seen, w_seen, ar_seen;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    forever begin
      @(negedge s_axi_aclk);
      if (!busy) begin
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        if (aw_seen && w_seen) begin
          if (!m_axi_bvalid) begin
            if (b_wait >= cfg_b_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_resp; end
            else b_wait++;
          end
          if (m_axi_bvalid && m_axi_bready) begin b_cnt++; aw_seen = 0; w_seen = 0; b_wait = 0; end
        end else m_axi_bvalid = 0;
        if (ar_seen) begin
          if (!m_axi_rvalid) begin
            if (r_wait >= cfg_r_dly) begin
              m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rdata = cfg_rdata;
            end else r_wait++;
          end
          if (m_axi_rvalid && m_axi_rready) begin r_cnt++; ar_seen = 0; r_wait = 0; end
        end else m_axi_rvalid = 0;
        if (m_axi_awvalid) begin
          aw_hi++;
          m_axi_awready = (aw_wait >= cfg_aw_dly);
          if (m_axi_awready) begin aw_cnt++; seen_awaddr = m_axi_awaddr; aw_seen = 1; aw_wait = 0; end
          else aw_wait++;
        end else m_axi_awready = 0;
        if (m_axi_wvalid) begin
          w_hi++;
          m_axi_wready = (w_wait >= cfg_w_dly);
          if (m_axi_wready) begin
            w_cnt++; seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; w_seen = 1; w_wait = 0;
          end else w_wait++;
        end else m_axi_wready = 0;
        if (m_axi_arvalid) begin
          m_axi_arready = (ar_wait >= cfg_ar_dly);
          if (m_axi_arready) begin ar_cnt++; seen_araddr = m_axi_araddr; ar_seen = 1; ar_wait = 0; end
          else ar_wait++;
        end else m_axi_arready = 0;
      end
    end
  end

  // One complete command. d_a = AW or AR delay, d_w = W delay, d_r = B or R delay
  // (in cycles after the channel becomes eligible); hold = cycles rsp_ready stays low.
  task automatic run_cmd(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int d_a, input int d_w, input int d_r,
                         input logic [1:0] resp, input logic [31:0] rd, input int hold);
    int lat, exp_lat, m, n;
    bit to;
    int aw0, w0, b0, ar0, r0, awh0, wh0;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    cfg_aw_dly = d_a; cfg_ar_dly = d_a; cfg_w_dly = d_w; cfg_b_dly = d_r; cfg_r_dly = d_r;
    cfg_resp = resp; cfg_rdata = rd;
    m = wr ? ((d_a > d_w) ? d_a : d_w) : d_a;
    to = (d_r >= TO);
    exp_lat   = 3 + m + (to ? TO - 1 : d_r);
    exp_resp  = to ? 2'b10 : resp;
    exp_rdata = (wr || to) ? 32'h0 : rd;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; awh0 = aw_hi; wh0 = w_hi;

    @(negedge s_axi_aclk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge s_axi_aclk); n++; end
    check("cmd_ready_idle", cmd_ready, 1);
    lat = 0;
    do begin
      @(negedge s_axi_aclk);
      if (lat == 0) begin
        cmd_valid = 0; cmd_addr = ~addr; cmd_wdata = $urandom; cmd_wstrb = ~ws;
      end
      lat++;
    end while (!rsp_valid && lat < 100);
    check("rsp_valid", rsp_valid, 1);
    check("latency", lat, exp_lat);
    check("rsp_resp", rsp_resp, exp_resp);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_timeout", rsp_timeout, to);
    check("busy_rsp", busy, 1);
    check("ready_low_rsp", {m_axi_bready, m_axi_rready}, 0);
    if (wr) begin
      check("aw_count", aw_cnt - aw0, 1);
      check("w_count", w_cnt - w0, 1);
      check("awaddr", seen_awaddr, addr);
      check("wdata", seen_wdata, wd);
      check("wstrb", seen_wstrb, ws);
      check("awvalid_cycles", aw_hi - awh0, d_a + 1);
      check("wvalid_cycles", w_hi - wh0, d_w + 1);
    end else begin
      check("ar_count", ar_cnt - ar0, 1);
      check("araddr", seen_araddr, addr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge s_axi_aclk);
      check("hold_valid_cmdrdy", {rsp_valid, cmd_ready}, 2'b10);
      check("hold_resp", {rsp_timeout, rsp_resp}, {to, exp_resp});
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_ready_low", {m_axi_bready, m_axi_rready}, 0);
    end
    check("b_count", b_cnt - b0, (wr && !to) ? 1 : 0);
    check("r_count", r_cnt - r0, (!wr && !to) ? 1 : 0);
    rsp_ready = 1;
    @(negedge s_axi_aclk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy_to", {busy, rsp_timeout}, 0);
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 s_axi_aresetn = 0;
    #2;
    check("rst_cmd_ready_busy", {cmd_ready, busy}, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_wdata", m_axi_wdata, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1;
    @(negedge s_axi_aclk);
    check("rel_cmd_ready", cmd_ready, 1);

    run_cmd(1, 9'h000, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
    run_cmd(1, 9'h010, 32'h1234_5678, 4'h3, 3, 0, 0, 2'b00, 32'h0, 0);
    run_cmd(1, 9'h014, 32'hCAFE_F00D, 4'hC, 0, 2, 1, 2'b01, 32'h0, 0);
    run_cmd(0, 9'h008, 32'h0, 4'h0, 0, 0, 5, 2'b00, 32'h0000_00FF, 0);
    run_cmd(0, 9'h00C, 32'h0, 4'h0, 1, 0, 16, 2'b00, 32'hDEAD_BEEF, 3);
    run_cmd(0, 9'h00C, 32'h0, 4'h0, 0, 0, 1000, 2'b00, 32'hDEAD_BEEF, 0);
    run_cmd(0, 9'h018, 32'h0, 4'h0, 0, 0, 15, 2'b01, 32'h0BAD_CAFE, 0);
    run_cmd(1, 9'h01C, 32'h5555_AAAA, 4'hF, 0, 0, 16, 2'b00, 32'h0, 2);
    run_cmd(1, 9'h020, 32'h0F0F_0F0F, 4'hF, 1, 1, 2, 2'b10, 32'h0, 10);

    // abort a write mid-flight: valids must fall with reset, not at the next edge
    cfg_aw_dly = 1000; cfg_w_dly = 1000;
    @(negedge s_axi_aclk);
    cmd_write = 1; cmd_addr = 9'h040; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(negedge s_axi_aclk);
    cmd_valid = 0;
    check("midop_valids_high", {m_axi_awvalid, m_axi_wvalid, busy}, 3'b111);
    #2 s_axi_aresetn = 0;
    #1;
    check("midop_valids_low", {m_axi_awvalid, m_axi_wvalid, busy, cmd_ready}, 0);
    check("midop_rsp_low", {rsp_valid, m_axi_bready}, 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1;
    @(negedge s_axi_aclk);
    check("midop_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    run_cmd(0, 9'h004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'h7654_3210, 0);

    for (int k = 0; k < 24; k++) begin
      run_cmd(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 19), 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite initiator that turns a simple single-beat command stream into AXI4-Lite write and read transactions.
- Returns the response and read data on a response stream.
- Drives the slave side of the AXI GPIO register block (9-bit address, 32-bit data); used as the in-system register programmer and as the reference initiator in the GPIO environment.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 9, AXI address width.
- DATA_W, 32, AXI data width (STRB width = DATA_W/8).
- TIMEOUT_CYCLES, 256, cycles to wait for B or R before a synthetic error response; 0 disables the timeout.

Ports:
- s_axi_aclk  in  1  clock; all logic on the rising edge.
- s_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response was synthesised by the timeout.
- busy  out  1  state != IDLE.
- m_axi_awaddr/awvalid out, awready in; m_axi_wdata/wstrb/wvalid out, wready in; m_axi_bresp in, bvalid in, bready out; m_axi_araddr/arvalid out, arready in; m_axi_rdata/rresp/rvalid in, rready out. Widths per AXI4-Lite with ADDR_W/DATA_W.

Behaviour:
- Reset (s_axi_aresetn low, async): state IDLE; all m_axi valid/ready, rsp_valid, rsp_timeout and busy = 0; addr/data/strb/rdata/resp registers = 0; timeout counter = 0.
- cmd_ready: 1 only in IDLE with reset released; combinational from registered state.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: on cmd_valid & cmd_ready, latch all cmd_* fields. Next state is WR_AW_W (write) or RD_AR (read).
  - awvalid+wvalid (write) or arvalid (read) are high in the cycle after acceptance.
- WR_AW_W:
  - awvalid and wvalid are asserted together.
  - Each drops the cycle after its own handshake; a handshake on either channel may come first or both may be simultaneous.
  - When both handshakes are done, go to WR_B with bready=1 in the next cycle.
  - Valids are never withdrawn before their handshake; no timeout in this state.
- WR_B: bready=1. On bvalid: capture bresp, set rdata=0, bready=0, go to RSP.
- RD_AR: arvalid held until arready, then go to RD_R with rready=1 next cycle; no timeout.
- RD_R: rready=1. On rvalid: capture rdata and rresp, rready=0, go to RSP.
- Timeout:
  - The counter clears on entering WR_B or RD_R and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES without bvalid/rvalid: resp=2'b10, rdata=0, rsp_timeout=1, drop bready/rready, go to RSP.
  - A bvalid/rvalid arriving in the same cycle the count expires takes priority (normal response).
  - Late B/R beats after a timeout are not consumed (ready stays 0).
- RSP:
  - rsp_valid=1 with rsp_* stable until rsp_ready.
  - On the handshake: rsp_valid=0, rsp_timeout=0, go to IDLE. The next command can be accepted in the following cycle; no combinational command-to-response bypass.
- Minimum latency with a zero-wait slave: accept T, AW/W handshake T+1, B handshake T+2, rsp_valid T+3, cmd_ready T+4 if rsp_ready is already high at T+3.
- Reset mid-transaction: all outputs return to reset values immediately. The in-flight command is dropped with no response.
- AXI rule: valid never depends combinationally on ready.

Test Plan:
- Write: addr 0x000, data 0xA5A5_5A5A, strb 0xF, slave ready immediately -> awaddr=0x000 and wdata=0xA5A5_5A5A in one beat; rsp_valid at T+3 with resp 2'b00 and rdata 0.
- Split handshakes: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; exactly one B accepted; resp 2'b00.
- Read: addr 0x008; slave returns rdata 0x0000_00FF, rresp 2'b00 after 5 cycles -> rsp_rdata=0x0000_00FF, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16, read with no rvalid -> after 16 cycles in RD_R, rsp_resp=2'b10, rsp_timeout=1, rready=0.
  - Repeat with rvalid arriving on the expiry cycle -> normal response returned.
- Backpressure and error: write with bresp 2'b10 and rsp_ready held low 10 cycles -> rsp fields stable, cmd_ready=0 throughout, then one handshake and return to IDLE.
- Reset mid-op: deassert s_axi_aresetn while awvalid is high -> awvalid/wvalid go low asynchronously; after release, cmd_ready=1 and a new read to 0x004 completes normally.
